// File: rtl/calendar_ctrl_pkg.sv
// Shared types, BCD constants and date helpers for the calendar controller.
// Used by calendar_ctrl and cal_month_len.
package calendar_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_SET_Y = 2'd1,
    MODE_SET_M = 2'd2,
    MODE_SET_D = 2'd3
  } mode_e;

  localparam logic [7:0]  BCD_01   = 8'h01;
  localparam logic [7:0]  BCD_12   = 8'h12;
  localparam logic [7:0]  BCD_28   = 8'h28;
  localparam logic [7:0]  BCD_29   = 8'h29;
  localparam logic [7:0]  BCD_30   = 8'h30;
  localparam logic [7:0]  BCD_31   = 8'h31;
  localparam logic [15:0] YEAR_MIN = 16'h2000;
  localparam logic [15:0] YEAR_MAX = 16'h2099;

  // Leap test on the two low BCD digits; valid for 2000..2099.
  function automatic logic is_leap(input logic [7:0] yl);
    logic [3:0] o;
    o = yl[3:0];
    if (yl[4])
      return (o == 4'd2) || (o == 4'd6);
    else
      return (o == 4'd0) || (o == 4'd4) || (o == 4'd8);
  endfunction

  // Two-digit BCD increment with digit-wise carry (no wrap at 99).
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = v[7:4];
    lo = v[3:0];
    if (lo == 4'd9) begin
      lo = 4'd0;
      hi = hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  // Year step inside 2000..2099, wrapping to 2000.
  function automatic logic [15:0] year_inc(input logic [15:0] y);
    if (y == YEAR_MAX)
      return YEAR_MIN;
    else
      return {y[15:8], bcd2_inc(y[7:0])};
  endfunction

endpackage

// File: rtl/cal_month_len.sv
// Month length lookup: BCD month + low BCD year byte -> BCD day count.
// Ports: month_bcd (01..12), year_lo (00..99), len_bcd (28..31).
module cal_month_len
  import calendar_ctrl_pkg::*;
(
  input  logic [7:0] month_bcd,
  input  logic [7:0] year_lo,
  output logic [7:0] len_bcd
);

  always_comb begin
    len_bcd = BCD_31;
    case (month_bcd)
      8'h02:
        len_bcd = is_leap(year_lo) ? BCD_29 : BCD_28;
      8'h04, 8'h06, 8'h09, 8'h11:
        len_bcd = BCD_30;
      default: ;
    endcase
  end

endmodule

// File: rtl/calendar_ctrl.sv
// Calendar date sequencer with a RUN/SET_Y/SET_M/SET_D edit FSM and blink.
// Ports: clk, reset (sync, low), tick, btn_mode, btn_inc -> BCD date, mode, blink_on, day_adv.
module calendar_ctrl
  import calendar_ctrl_pkg::*;
#(
  parameter logic [23:0] BLINK_CYC = 24'd6_000_000,
  parameter logic [15:0] RST_YEAR  = 16'h2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [15:0] year_bcd,
  output logic [7:0]  month_bcd,
  output logic [7:0]  day_bcd,
  output logic [1:0]  mode,
  output logic        blink_on,
  output logic        day_adv
);

  localparam logic [23:0] BLINK_TC = BLINK_CYC - 24'd1;

  mode_e       mode_q, mode_d;
  logic [15:0] year_q, year_d;
  logic [7:0]  month_q, month_d;
  logic [7:0]  day_q, day_d;
  logic        blink_q, blink_d;
  logic [23:0] cnt_q, cnt_d;
  logic        day_adv_q, day_adv_d;

  logic [15:0] year_pre;
  logic [7:0]  month_pre;
  logic [7:0]  day_pre;
  logic [7:0]  len_cur;
  logic [7:0]  len_nxt;
  logic        adv;
  logic        inc_ok;

  // len_cur drives day increment; len_nxt clamps after a year/month change.
  cal_month_len u_len_cur (
    .month_bcd (month_q),
    .year_lo   (year_q[7:0]),
    .len_bcd   (len_cur)
  );

  cal_month_len u_len_nxt (
    .month_bcd (month_pre),
    .year_lo   (year_pre[7:0]),
    .len_bcd   (len_nxt)
  );

  always_ff @(posedge clk) begin
    if (!reset)
      mode_q <= MODE_RUN;
    else
      mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (btn_mode) begin
      case (mode_q)
        MODE_RUN:   mode_d = MODE_SET_Y;
        MODE_SET_Y: mode_d = MODE_SET_M;
        MODE_SET_M: mode_d = MODE_SET_D;
        MODE_SET_D: mode_d = MODE_RUN;
        default:    mode_d = MODE_RUN;
      endcase
    end
  end

  // btn_mode wins over btn_inc; tick only counts in RUN.
  always_comb begin
    adv       = tick && (mode_q == MODE_RUN);
    inc_ok    = btn_inc && !btn_mode;
    year_pre  = year_q;
    month_pre = month_q;
    day_pre   = day_q;
    if (adv) begin
      if (day_q >= len_cur) begin
        day_pre = BCD_01;
        if (month_q == BCD_12) begin
          month_pre = BCD_01;
          year_pre  = year_inc(year_q);
        end else begin
          month_pre = bcd2_inc(month_q);
        end
      end else begin
        day_pre = bcd2_inc(day_q);
      end
    end else if (inc_ok) begin
      case (mode_q)
        MODE_SET_Y:
          year_pre = year_inc(year_q);
        MODE_SET_M:
          month_pre = (month_q == BCD_12) ? BCD_01
                                          : bcd2_inc(month_q);
        MODE_SET_D:
          day_pre = (day_q >= len_cur) ? BCD_01
                                       : bcd2_inc(day_q);
        default: ;
      endcase
    end
  end

  always_comb begin
    year_d    = year_pre;
    month_d   = month_pre;
    day_d     = (day_pre > len_nxt) ? len_nxt : day_pre;
    day_adv_d = adv;
    if (btn_mode || (mode_q == MODE_RUN)) begin
      cnt_d   = 24'd0;
      blink_d = 1'b1;
    end else if (cnt_q == BLINK_TC) begin
      cnt_d   = 24'd0;
      blink_d = ~blink_q;
    end else begin
      cnt_d   = cnt_q + 24'd1;
      blink_d = blink_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      year_q    <= RST_YEAR;
      month_q   <= BCD_01;
      day_q     <= BCD_01;
      blink_q   <= 1'b1;
      cnt_q     <= 24'd0;
      day_adv_q <= 1'b0;
    end else begin
      year_q    <= year_d;
      month_q   <= month_d;
      day_q     <= day_d;
      blink_q   <= blink_d;
      cnt_q     <= cnt_d;
      day_adv_q <= day_adv_d;
    end
  end

  assign year_bcd  = year_q;
  assign month_bcd = month_q;
  assign day_bcd   = day_q;
  assign mode      = mode_q;
  assign blink_on  = blink_q;
  assign day_adv   = day_adv_q;

endmodule

// File: tb/tb_calendar_ctrl.sv
// Scoreboard bench for calendar_ctrl with an integer date reference model.
// Driver pushes expected state per cycle; monitor pops and compares.
module tb_calendar_ctrl;

  localparam int BC = 4;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        btn_mode;
  logic        btn_inc;
  logic [15:0] year_bcd;
  logic [7:0]  month_bcd;
  logic [7:0]  day_bcd;
  logic [1:0]  mode;
  logic        blink_on;
  logic        day_adv;

  calendar_ctrl #(
    .BLINK_CYC (24'd4),
    .RST_YEAR  (16'h2000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .year_bcd  (year_bcd),
    .month_bcd (month_bcd),
    .day_bcd   (day_bcd),
    .mode      (mode),
    .blink_on  (blink_on),
    .day_adv   (day_adv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] y;
    logic [7:0]  m;
    logic [7:0]  d;
    logic [1:0]  md;
    logic        bl;
    logic        adv;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  int my = 2000, mm = 1, mdy = 1, mmode = 0, mk = 0;
  bit madv = 0;

  function automatic int mlen(int y, int m);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic logic [7:0] to_bcd2(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_update(bit t, bit bm, bit bi, bit rn);
    if (!rn) begin
      my = 2000; mm = 1; mdy = 1; mmode = 0; mk = 0; madv = 0;
      return;
    end
    madv = (mmode == 0) && t;
    if (madv) begin
      mdy++;
      if (mdy > mlen(my, mm)) begin
        mdy = 1;
        mm++;
        if (mm > 12) begin
          mm = 1;
          my = (my == 2099) ? 2000 : my + 1;
        end
      end
    end else if (bi && !bm && mmode != 0) begin
      if (mmode == 1) my = (my == 2099) ? 2000 : my + 1;
      if (mmode == 2) mm = (mm == 12) ? 1 : mm + 1;
      if (mmode == 3) mdy = (mdy == mlen(my, mm)) ? 1 : mdy + 1;
    end
    if (mdy > mlen(my, mm)) mdy = mlen(my, mm);
    if (bm) begin
      mmode = (mmode + 1) % 4;
      mk = 0;
    end else if (mmode == 0) begin
      mk = 0;
    end else begin
      mk++;
    end
  endtask

  task automatic step(bit t, bit bm, bit bi, bit rn);
    exp_t e;
    tick = t; btn_mode = bm; btn_inc = bi; reset = rn;
    @(posedge clk);
    model_update(t, bm, bi, rn);
    e.y   = {8'h20, to_bcd2(my - 2000)};
    e.m   = to_bcd2(mm);
    e.d   = to_bcd2(mdy);
    e.md  = 2'(mmode);
    e.bl  = (mmode == 0) ? 1'b1 : (((mk / BC) % 2) == 0);
    e.adv = madv;
    q.push_back(e);
    #1;
    tick = 0; btn_mode = 0; btn_inc = 0;
  endtask

  task automatic set_date(int y, int m, int d);
    int n;
    while (mmode != 0) step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    n = 0;
    while (my != y && n < 200) begin step(0, 0, 1, 1); n++; end
    step(0, 1, 0, 1);
    n = 0;
    while (mm != m && n < 20) begin step(0, 0, 1, 1); n++; end
    step(0, 1, 0, 1);
    n = 0;
    while (mdy != d && n < 40) begin step(0, 0, 1, 1); n++; end
    step(0, 1, 0, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if ({year_bcd, month_bcd, day_bcd, mode, blink_on, day_adv} !==
          {e.y, e.m, e.d, e.md, e.bl, e.adv}) begin
        miscompares++;
        $display("FAIL vec%0d: got %h-%h-%h mode=%0d blink=%b adv=%b, want %h-%h-%h mode=%0d blink=%b adv=%b",
                 vectors, year_bcd, month_bcd, day_bcd, mode, blink_on, day_adv,
                 e.y, e.m, e.d, e.md, e.bl, e.adv);
      end
    end
  end

  initial begin
    tick = 0; btn_mode = 0; btn_inc = 0; reset = 0;
    @(posedge clk); #1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (31) step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    set_date(2023, 2, 28);
    step(1, 0, 0, 1);
    set_date(2024, 2, 28);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    set_date(2099, 12, 31);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    set_date(2024, 1, 31);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 0, 1, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 0, 1, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    repeat (10) step(1, 0, 0, 1);
    step(0, 1, 1, 1);
    step(1, 1, 0, 1);
    repeat (12) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(1, 0) == 1,
           $urandom_range(7, 0) == 0,
           $urandom_range(2, 0) == 0,
           $urandom_range(299, 0) != 0);
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
